// File: rtl/mcp320x_pkg.sv
// mcp320x_pkg
//   Shared types and elaboration helpers for the multi-channel MCP320x reader.
//   - state_t          : frame engine FSM states
//   - DW_MIN / DW_MAX  : supported ADC resolutions (MCP3001 .. MCP3201)
//   - calc_half        : system clocks per SCLK phase, never below 1
//   - calc_nclk        : SCLK periods per conversion frame
//   - calc_frame_clks  : system clocks between conversion starts
package mcp320x_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    SHIFT = 2'd2,
    TAIL  = 2'd3
  } state_t;

  localparam int DW_MIN = 10;
  localparam int DW_MAX = 12;

  function automatic int calc_half(input int clock_freq, input int sclk_freq);
    int h;
    h = clock_freq / (2 * sclk_freq);
    return (h < 1) ? 1 : h;
  endfunction

  // Two sample-window clocks, one null bit, then the data bits.
  function automatic int calc_nclk(input int data_width);
    return data_width + 3;
  endfunction

  function automatic int calc_frame_clks(input int clock_freq, input int sample_rate);
    return clock_freq / sample_rate;
  endfunction

endpackage

// File: rtl/mcp320x_frame_engine.sv
// mcp320x_frame_engine
//   Free-running frame counter plus the SPI framing FSM shared by all ADCs.
//   Ports:
//     clock, reset  : system clock, synchronous active-high reset
//     enable_i      : start a new frame on the next frame tick
//     spi_clk_o     : shared SCLK, idle low (registered)
//     spi_ssn_o     : shared chip select, active low (registered)
//     shift_en      : high for the one cycle in which SCLK has just risen on a
//                     data-bit edge; MISO is captured at the end of that cycle
//     frame_done    : one-cycle strobe in the last cycle of the tCSH tail
module mcp320x_frame_engine
  import mcp320x_pkg::*;
#(
  parameter int HALF       = 4,
  parameter int NCLK       = 15,
  parameter int FRAME_CLKS = 160
) (
  input  logic clock,
  input  logic reset,
  input  logic enable_i,
  output logic spi_clk_o,
  output logic spi_ssn_o,
  output logic shift_en,
  output logic frame_done
);

  localparam int FC_W = (FRAME_CLKS > 1) ? $clog2(FRAME_CLKS) : 1;
  localparam int PH_W = $clog2(HALF + 1);
  localparam int BC_W = $clog2(NCLK + 1);

  logic [FC_W-1:0] frame_cnt;
  logic            tick;
  state_t          state;
  logic [PH_W-1:0] ph;
  logic [BC_W-1:0] bit_cnt;
  logic            ph_last;

  assign tick    = (frame_cnt == FC_W'(FRAME_CLKS - 1));
  assign ph_last = (ph == PH_W'(HALF - 1));

  // Edges 1..3 are the sample window and null bit; only later edges carry data.
  assign shift_en   = (state == SHIFT) && spi_clk_o && (ph == '0) && (bit_cnt >= BC_W'(4));
  assign frame_done = (state == TAIL) && ph_last;

  // Frame tick keeps running while disabled so restarts stay on the sample grid.
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (tick) begin
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + FC_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      ph        <= '0;
      bit_cnt   <= '0;
      spi_clk_o <= 1'b0;
      spi_ssn_o <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          ph <= '0;
          if (tick && enable_i) begin
            state     <= LEAD;
            spi_ssn_o <= 1'b0;
          end
        end
        LEAD: begin
          if (ph_last) begin
            state     <= SHIFT;
            spi_clk_o <= 1'b1;
            bit_cnt   <= BC_W'(1);
            ph        <= '0;
          end else begin
            ph <= ph + PH_W'(1);
          end
        end
        SHIFT: begin
          if (ph_last) begin
            ph <= '0;
            if (spi_clk_o) begin
              spi_clk_o <= 1'b0;
            end else if (bit_cnt == BC_W'(NCLK)) begin
              state     <= TAIL;
              spi_ssn_o <= 1'b1;
            end else begin
              spi_clk_o <= 1'b1;
              bit_cnt   <= bit_cnt + BC_W'(1);
            end
          end else begin
            ph <= ph + PH_W'(1);
          end
        end
        TAIL: begin
          if (ph_last) begin
            state <= IDLE;
            ph    <= '0;
          end else begin
            ph <= ph + PH_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mcp320x_multi_adc.sv
// mcp320x_multi_adc
//   Reads CHANNELS MCP3001/3101/3201 ADCs over one shared SCLK/SSn pair,
//   optionally sums 2^AVG_LOG2 conversions, and presents the result on a
//   valid/ready port with overrun reporting.
//   Ports:
//     clock, reset   : system clock, synchronous active-high reset
//     enable_i       : run conversions; dropping it stops after the current frame
//     spi_clk_o      : shared SCLK, mode (0,0)
//     spi_ssn_o      : shared chip select, active low
//     spi_miso_i[k]  : MISO of ADC k
//     data_o         : channel k at [k*OUT_W +: OUT_W], unsigned sum
//     valid_o        : data_o holds an unaccepted result
//     ready_i        : downstream accepts when valid_o && ready_i
//     overrun_o      : one-cycle pulse when a pending result is overwritten
module mcp320x_multi_adc
  import mcp320x_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int CLOCK_FREQ  = 25000000,
  parameter int SCLK_FREQ   = 1000000,
  parameter int SAMPLE_RATE = 50000,
  parameter int DATA_WIDTH  = 12,
  parameter int AVG_LOG2    = 0
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic                                         enable_i,
  output logic                                         spi_clk_o,
  output logic                                         spi_ssn_o,
  input  logic [CHANNELS-1:0]                          spi_miso_i,
  output logic [CHANNELS*(DATA_WIDTH+AVG_LOG2)-1:0]    data_o,
  output logic                                         valid_o,
  input  logic                                         ready_i,
  output logic                                         overrun_o
);

  localparam int HALF       = calc_half(CLOCK_FREQ, SCLK_FREQ);
  localparam int NCLK       = calc_nclk(DATA_WIDTH);
  localparam int FRAME_CLKS = calc_frame_clks(CLOCK_FREQ, SAMPLE_RATE);
  localparam int OUT_W      = DATA_WIDTH + AVG_LOG2;
  localparam int CNT_W      = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  if (FRAME_CLKS < 2 * HALF * NCLK + 2 * HALF + 1) begin : g_bad_frame
    $error("mcp320x_multi_adc: frame period too short for SPI transfer");
  end
  if (CHANNELS < 1) begin : g_bad_channels
    $error("mcp320x_multi_adc: CHANNELS must be at least 1");
  end
  if (DATA_WIDTH < DW_MIN || DATA_WIDTH > DW_MAX) begin : g_bad_width
    $error("mcp320x_multi_adc: DATA_WIDTH must be 10..12");
  end

  logic shift_en;
  logic frame_done;

  mcp320x_frame_engine #(
    .HALF       (HALF),
    .NCLK       (NCLK),
    .FRAME_CLKS (FRAME_CLKS)
  ) u_engine (
    .clock      (clock),
    .reset      (reset),
    .enable_i   (enable_i),
    .spi_clk_o  (spi_clk_o),
    .spi_ssn_o  (spi_ssn_o),
    .shift_en   (shift_en),
    .frame_done (frame_done)
  );

  logic [CHANNELS-1:0][DATA_WIDTH-1:0] shift_p0;
  logic [CHANNELS-1:0][OUT_W-1:0]      acc_p1;
  logic [CNT_W-1:0]                    count_p1;
  logic                                vld_p1;
  logic                                clr_p1;

  // Stage p0: MSB-first deserialisation of every MISO line in parallel.
  // Exactly DATA_WIDTH shifts happen per frame, so no per-frame clear is needed.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_p0 <= '0;
    end else if (shift_en) begin
      for (int k = 0; k < CHANNELS; k++) begin
        shift_p0[k] <= {shift_p0[k][DATA_WIDTH-2:0], spi_miso_i[k]};
      end
    end
  end

  // Stage p1: accumulate finished words; clear one cycle later, after the
  // output stage has copied the sum, or when conversions are being stopped.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_p1   <= '0;
      count_p1 <= '0;
      vld_p1   <= 1'b0;
      clr_p1   <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      clr_p1 <= 1'b0;
      if (frame_done) begin
        for (int k = 0; k < CHANNELS; k++) begin
          acc_p1[k] <= acc_p1[k] + OUT_W'(shift_p0[k]);
        end
        count_p1 <= (count_p1 == CNT_LAST || !enable_i) ? '0 : count_p1 + CNT_W'(1);
        vld_p1   <= (count_p1 == CNT_LAST);
        clr_p1   <= (count_p1 == CNT_LAST) || !enable_i;
      end else if (clr_p1) begin
        acc_p1 <= '0;
      end
    end
  end

  // Stage p2: output register with valid/ready handshake. A new result always
  // wins; it only counts as an overrun if the old one was not taken this cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_o    <= '0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      overrun_o <= vld_p1 && valid_o && !ready_i;
      if (vld_p1) begin
        data_o  <= acc_p1;
        valid_o <= 1'b1;
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mcp320x_multi_adc.sv
// tb_mcp320x_multi_adc
//   Bench for mcp320x_multi_adc with three instances sharing clock and reset:
//     A: 2 x 12-bit, no averaging (timing, handshake, enable, reset)
//     B: 2 x 12-bit, AVG_LOG2=2 (oversampling sum)
//     C: 4 x 10-bit, no averaging (13-clock frame, channel packing)
//   Behavioural MCP320x models shift words out MSB first on falling SCLK and
//   drive 1 on the sample-window and null-bit edges.
module tb_mcp320x_multi_adc;

  localparam int CF = 8000000;
  localparam int SF = 1000000;
  localparam int SR = 50000;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset;

  logic en_a, rdy_a, sclk_a, ssn_a, vld_a, ovr_a;
  logic [1:0]  miso_a;
  logic [23:0] data_a;
  logic [11:0] word_a [2];
  int          edge_a;

  logic en_b, rdy_b, sclk_b, ssn_b, vld_b, ovr_b;
  logic [1:0]  miso_b;
  logic [27:0] data_b;
  logic [11:0] word_b [2];
  int          edge_b;

  logic en_c, rdy_c, sclk_c, ssn_c, vld_c, ovr_c;
  logic [3:0]  miso_c;
  logic [39:0] data_c;
  logic [9:0]  word_c [4];
  int          edge_c;

  logic [23:0] q_a[$];
  logic [27:0] q_b[$];
  logic [39:0] q_c[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  mcp320x_multi_adc #(.CHANNELS(2), .CLOCK_FREQ(CF), .SCLK_FREQ(SF), .SAMPLE_RATE(SR),
                      .DATA_WIDTH(12), .AVG_LOG2(0)) dut_a (
    .clock(clock), .reset(reset), .enable_i(en_a), .spi_clk_o(sclk_a), .spi_ssn_o(ssn_a),
    .spi_miso_i(miso_a), .data_o(data_a), .valid_o(vld_a), .ready_i(rdy_a), .overrun_o(ovr_a));

  mcp320x_multi_adc #(.CHANNELS(2), .CLOCK_FREQ(CF), .SCLK_FREQ(SF), .SAMPLE_RATE(SR),
                      .DATA_WIDTH(12), .AVG_LOG2(2)) dut_b (
    .clock(clock), .reset(reset), .enable_i(en_b), .spi_clk_o(sclk_b), .spi_ssn_o(ssn_b),
    .spi_miso_i(miso_b), .data_o(data_b), .valid_o(vld_b), .ready_i(rdy_b), .overrun_o(ovr_b));

  mcp320x_multi_adc #(.CHANNELS(4), .CLOCK_FREQ(CF), .SCLK_FREQ(SF), .SAMPLE_RATE(SR),
                      .DATA_WIDTH(10), .AVG_LOG2(0)) dut_c (
    .clock(clock), .reset(reset), .enable_i(en_c), .spi_clk_o(sclk_c), .spi_ssn_o(ssn_c),
    .spi_miso_i(miso_c), .data_o(data_c), .valid_o(vld_c), .ready_i(rdy_c), .overrun_o(ovr_c));

  // ADC models: the bit for rising edge e is presented after falling edge e-1.
  always @(negedge ssn_a) begin edge_a = 0; miso_a = '1; end
  always @(posedge sclk_a) edge_a = edge_a + 1;
  always @(negedge sclk_a) begin
    int b;
    #1;
    b = 14 - edge_a;
    for (int k = 0; k < 2; k++) miso_a[k] = (b >= 0 && b <= 11) ? word_a[k][b] : 1'b1;
  end

  always @(negedge ssn_b) begin edge_b = 0; miso_b = '1; end
  always @(posedge sclk_b) edge_b = edge_b + 1;
  always @(negedge sclk_b) begin
    int b;
    #1;
    b = 14 - edge_b;
    for (int k = 0; k < 2; k++) miso_b[k] = (b >= 0 && b <= 11) ? word_b[k][b] : 1'b1;
  end

  always @(negedge ssn_c) begin edge_c = 0; miso_c = '1; end
  always @(posedge sclk_c) edge_c = edge_c + 1;
  always @(negedge sclk_c) begin
    int b;
    #1;
    b = 12 - edge_c;
    for (int k = 0; k < 4; k++) miso_c[k] = (b >= 0 && b <= 9) ? word_c[k][b] : 1'b1;
  end

  task automatic step();
    @(negedge clock);
    cyc++;
  endtask

  task automatic wait_vld_a(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      step();
      if (vld_a) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_ssn_low_a(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      step();
      if (!ssn_a) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    n_checks++; if (sclk_a !== 1'b0) $display("FAIL reset_sclk: got %b want 0", sclk_a); else n_pass++;
    n_checks++; if (ssn_a !== 1'b1) $display("FAIL reset_ssn: got %b want 1", ssn_a); else n_pass++;
    n_checks++; if (data_a !== 24'h0) $display("FAIL reset_data: got %h want 0", data_a); else n_pass++;
    n_checks++; if (vld_a !== 1'b0) $display("FAIL reset_valid: got %b want 0", vld_a); else n_pass++;
    n_checks++; if (ovr_a !== 1'b0) $display("FAIL reset_overrun: got %b want 0", ovr_a); else n_pass++;
    n_checks++; if (data_b !== 28'h0) $display("FAIL reset_data_b: got %h want 0", data_b); else n_pass++;
    n_checks++; if (ssn_c !== 1'b1) $display("FAIL reset_ssn_c: got %b want 1", ssn_c); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    bit ok;
    logic [23:0] exp;
    int low, pulses, lat, t0;
    logic prev;
    q_a.push_back({12'h123, 12'hA5C});
    wait_vld_a(400, ok);
    exp = q_a.pop_front();
    n_checks++; if (!ok || data_a !== exp) $display("FAIL basic_first: got %h valid %b want %h", data_a, vld_a, exp); else n_pass++;
    step();
    q_a.push_back({12'h123, 12'hA5C});
    wait_ssn_low_a(300, ok);
    n_checks++; if (!ok) $display("FAIL basic_ssn_fall: got ssn %b want 0", ssn_a); else n_pass++;
    low = 0; pulses = 0; prev = sclk_a;
    while (ssn_a == 1'b0 && low < 300) begin
      low++;
      step();
      if (sclk_a && !prev) pulses++;
      prev = sclk_a;
    end
    n_checks++; if (low != 124) $display("FAIL basic_ssn_low: got %0d want 124", low); else n_pass++;
    n_checks++; if (pulses != 15) $display("FAIL basic_sclk_pulses: got %0d want 15", pulses); else n_pass++;
    lat = 0;
    while (!vld_a && lat < 20) begin step(); lat++; end
    n_checks++; if (lat != 5) $display("FAIL basic_latency: got %0d want 5", lat); else n_pass++;
    exp = q_a.pop_front();
    n_checks++; if (data_a !== exp) $display("FAIL basic_data: got %h want %h", data_a, exp); else n_pass++;
    t0 = cyc;
    step();
    n_checks++; if (vld_a !== 1'b0) $display("FAIL basic_valid_drop: got %b want 0", vld_a); else n_pass++;
    q_a.push_back({12'h123, 12'hA5C});
    wait_vld_a(400, ok);
    n_checks++; if (!ok || cyc - t0 != 160) $display("FAIL basic_interval: got %0d want 160", cyc - t0); else n_pass++;
    exp = q_a.pop_front();
    n_checks++; if (data_a !== exp) $display("FAIL basic_data2: got %h want %h", data_a, exp); else n_pass++;
    step();
  endtask

  task automatic test_patterns();
    bit ok;
    logic [23:0] exp;
    logic [11:0] tab [4][2];
    tab[0][0] = 12'h000; tab[0][1] = 12'hFFF;
    tab[1][0] = 12'h555; tab[1][1] = 12'hAAA;
    tab[2][0] = 12'hFFF; tab[2][1] = 12'h000;
    tab[3][0] = 12'($urandom); tab[3][1] = 12'($urandom);
    for (int i = 0; i < 4; i++) begin
      word_a[0] = tab[i][0];
      word_a[1] = tab[i][1];
      q_a.push_back({tab[i][1], tab[i][0]});
      wait_vld_a(400, ok);
      exp = q_a.pop_front();
      n_checks++; if (!ok || data_a !== exp) $display("FAIL pattern%0d: got %h valid %b want %h", i, data_a, vld_a, exp); else n_pass++;
      step();
    end
  endtask

  task automatic test_overrun();
    bit ok, dropped;
    logic [23:0] exp;
    rdy_a = 1'b0;
    word_a[0] = 12'h00F; word_a[1] = 12'h0F0;
    q_a.push_back({12'h0F0, 12'h00F});
    wait_vld_a(400, ok);
    exp = q_a.pop_front();
    n_checks++; if (!ok || data_a !== exp) $display("FAIL ovr_first: got %h want %h", data_a, exp); else n_pass++;
    n_checks++; if (ovr_a !== 1'b0) $display("FAIL ovr_first_flag: got %b want 0", ovr_a); else n_pass++;
    word_a[0] = 12'h800; word_a[1] = 12'h7FF;
    q_a.push_back({12'h7FF, 12'h800});
    ok = 1'b0; dropped = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (!vld_a) dropped = 1'b1;
      if (ovr_a) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok) $display("FAIL ovr_pulse: got %b want 1", ovr_a); else n_pass++;
    n_checks++; if (dropped) $display("FAIL ovr_valid_held: got dropped want held"); else n_pass++;
    exp = q_a.pop_front();
    n_checks++; if (data_a !== exp) $display("FAIL ovr_data: got %h want %h", data_a, exp); else n_pass++;
    step();
    n_checks++; if (ovr_a !== 1'b0) $display("FAIL ovr_one_cycle: got %b want 0", ovr_a); else n_pass++;
    n_checks++; if (vld_a !== 1'b1) $display("FAIL ovr_still_valid: got %b want 1", vld_a); else n_pass++;
    rdy_a = 1'b1;
    step();
    n_checks++; if (vld_a !== 1'b0) $display("FAIL ovr_accept: got %b want 0", vld_a); else n_pass++;
  endtask

  task automatic test_enable();
    bit ok, stayed;
    logic [23:0] exp;
    int t_fall;
    word_a[0] = 12'hCBA; word_a[1] = 12'h321;
    q_a.push_back({12'h321, 12'hCBA});
    wait_ssn_low_a(300, ok);
    t_fall = cyc;
    repeat (40) step();
    en_a = 1'b0;
    wait_vld_a(300, ok);
    exp = q_a.pop_front();
    n_checks++; if (!ok || data_a !== exp) $display("FAIL en_last_frame: got %h valid %b want %h", data_a, vld_a, exp); else n_pass++;
    stayed = 1'b1;
    for (int i = 0; i < 400; i++) begin
      step();
      if (!ssn_a || vld_a) stayed = 1'b0;
    end
    n_checks++; if (!stayed) $display("FAIL en_idle: got activity want idle"); else n_pass++;
    en_a = 1'b1;
    q_a.push_back({12'h321, 12'hCBA});
    wait_ssn_low_a(200, ok);
    n_checks++; if (!ok || ((cyc - t_fall) % 160) != 0) $display("FAIL en_restart_grid: got offset %0d want 0", (cyc - t_fall) % 160); else n_pass++;
    wait_vld_a(300, ok);
    exp = q_a.pop_front();
    n_checks++; if (!ok || data_a !== exp) $display("FAIL en_restart_data: got %h want %h", data_a, exp); else n_pass++;
    step();
  endtask

  task automatic test_avg();
    bit ok;
    logic prev;
    int frames, t0;
    logic [27:0] exp;
    q_b.push_back({14'h0004, 14'h3FFC});
    en_b = 1'b1;
    ok = 1'b0; frames = 0; prev = ssn_b;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (ssn_b && !prev) frames++;
      prev = ssn_b;
      if (vld_b) begin ok = 1'b1; break; end
    end
    exp = q_b.pop_front();
    n_checks++; if (!ok || data_b !== exp) $display("FAIL avg_data: got %h valid %b want %h", data_b, vld_b, exp); else n_pass++;
    n_checks++; if (frames != 4) $display("FAIL avg_frames: got %0d want 4", frames); else n_pass++;
    t0 = cyc;
    q_b.push_back({14'h0004, 14'h3FFC});
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (vld_b) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok || cyc - t0 != 640) $display("FAIL avg_interval: got %0d want 640", cyc - t0); else n_pass++;
    exp = q_b.pop_front();
    n_checks++; if (data_b !== exp) $display("FAIL avg_data2: got %h want %h", data_b, exp); else n_pass++;
    en_b = 1'b0;
  endtask

  task automatic test_width();
    bit ok;
    logic prev;
    int pulses;
    logic [39:0] exp;
    q_c.push_back({word_c[3], word_c[2], word_c[1], word_c[0]});
    en_c = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (!ssn_c) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok) $display("FAIL width_ssn_fall: got %b want 0", ssn_c); else n_pass++;
    pulses = 0; prev = sclk_c;
    for (int i = 0; i < 300 && !ssn_c; i++) begin
      step();
      if (sclk_c && !prev) pulses++;
      prev = sclk_c;
    end
    n_checks++; if (pulses != 13) $display("FAIL width_sclk_pulses: got %0d want 13", pulses); else n_pass++;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (vld_c) begin ok = 1'b1; break; end
    end
    exp = q_c.pop_front();
    n_checks++; if (!ok || data_c !== exp) $display("FAIL width_data: got %h valid %b want %h", data_c, vld_c, exp); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (data_c[k*10 +: 10] !== word_c[k]) $display("FAIL width_ch%0d: got %h want %h", k, data_c[k*10 +: 10], word_c[k]);
      else n_pass++;
    end
    en_c = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [23:0] exp;
    rdy_a = 1'b0;
    wait_vld_a(400, ok);
    word_a[0] = 12'h9AB; word_a[1] = 12'h456;
    wait_ssn_low_a(300, ok);
    repeat (30) step();
    reset = 1'b1;
    step();
    n_checks++; if (ssn_a !== 1'b1) $display("FAIL rstmid_ssn: got %b want 1", ssn_a); else n_pass++;
    n_checks++; if (sclk_a !== 1'b0) $display("FAIL rstmid_sclk: got %b want 0", sclk_a); else n_pass++;
    n_checks++; if (vld_a !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", vld_a); else n_pass++;
    n_checks++; if (data_a !== 24'h0) $display("FAIL rstmid_data: got %h want 0", data_a); else n_pass++;
    repeat (2) step();
    reset = 1'b0;
    rdy_a = 1'b1;
    q_a.push_back({12'h456, 12'h9AB});
    wait_vld_a(400, ok);
    exp = q_a.pop_front();
    n_checks++; if (!ok || data_a !== exp) $display("FAIL rstmid_fresh: got %h valid %b want %h", data_a, vld_a, exp); else n_pass++;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    en_a = 1'b1; rdy_a = 1'b1;
    en_b = 1'b0; rdy_b = 1'b1;
    en_c = 1'b0; rdy_c = 1'b1;
    miso_a = '1; miso_b = '1; miso_c = '1;
    edge_a = 0; edge_b = 0; edge_c = 0;
    word_a[0] = 12'hA5C; word_a[1] = 12'h123;
    word_b[0] = 12'hFFF; word_b[1] = 12'h001;
    word_c[0] = 10'h3A5; word_c[1] = 10'h0F0; word_c[2] = 10'h201; word_c[3] = 10'h1FE;
    test_reset();
    test_basic();
    test_patterns();
    test_overrun();
    test_enable();
    test_avg();
    test_width();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
